// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock; result = {remainder, quotient}, both registered.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t             state_q, state_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic [2*WIDTH:0]   work_q, work_n;     // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
    logic [WIDTH-1:0]   dvsr_q, dvsr_n;
    logic               neg_a_q, neg_a_n;   // dividend was negative (signed mode only)
    logic               neg_b_q, neg_b_n;   // divisor was negative (signed mode only)
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH:0]   step;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

    // Operand magnitudes and one restoring shift-subtract step on the working register
    always_comb begin
        abs_a = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        abs_b = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
        // Shifted partial remainder is work_q[2W:W-1]; one extra top bit carries the borrow.
        diff  = {1'b0, work_q[2*WIDTH:WIDTH-1]} - {2'b00, dvsr_q};
        if (diff[WIDTH+1])
            step = {work_q[2*WIDTH-1:0], 1'b0};
        else
            step = {diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
        quo_raw = step[WIDTH-1:0];
        rem_raw = step[2*WIDTH-1:WIDTH];
        // Quotient sign is the XOR of operand signs; remainder follows the dividend.
        quo_fix = (neg_a_q ^ neg_b_q) ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix = neg_a_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state and next-output logic for the FREE/BYZERO/ON/END sequencer
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        work_n   = work_q;
        dvsr_n   = dvsr_q;
        neg_a_n  = neg_a_q;
        neg_b_n  = neg_b_q;
        result_n = result;
        ready_n  = ready;
        case (state_q)
            FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                // annul takes priority over a simultaneous start
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n = ON;
                        cnt_n   = '0;
                        work_n  = {{(WIDTH+1){1'b0}}, abs_a};
                        dvsr_n  = abs_b;
                        neg_a_n = signed_div & opdata1[WIDTH-1];
                        neg_b_n = signed_div & opdata2[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                state_n  = END;
                result_n = '0;
                ready_n  = 1'b1;
            end
            ON: begin
                if (annul) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else begin
                    work_n = step;
                    cnt_n  = cnt_q + 1'b1;
                    // Last step lands straight in the result register with sign fixed.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_n  = END;
                        result_n = {rem_fix, quo_fix};
                        ready_n  = 1'b1;
                    end
                end
            end
            END: begin
                if (!start || annul) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: begin
                state_n  = FREE;
                result_n = '0;
                ready_n  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            work_q  <= work_n;
            dvsr_q  <= dvsr_n;
            neg_a_q <= neg_a_n;
            neg_b_q <= neg_b_n;
            result  <= result_n;
            ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, hand-written corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int nvec  = 0;
    int nfail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2),
        .start(start), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint q, r, x, y;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Step one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready (caller has already counted 'edges' of them).
    task automatic wait_ready(inout int edges);
        while (!ready && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    // Full request: hold start until ready, check latency, result, hold, and release.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string nm);
        int edges;
        edges      = 0;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        wait_ready(edges);
        chk({nm, " latency"}, 64'(edges), 64'(lat));
        chk({nm, " result"}, result, exp);
        tick();
        tick();
        chk({nm, " hold ready"}, 64'(ready), 64'd1);
        chk({nm, " hold result"}, result, exp);
        start = 1'b0;
        tick();
        chk({nm, " release ready"}, 64'(ready), 64'd0);
        chk({nm, " release result"}, result, 64'd0);
    endtask

    initial begin
        int edges;
        logic early;
        logic        rs;
        logic [31:0] ra, rb;
        int          mode;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, "u100/7"};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, "s-7/2"};
        tbl[2] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33, "s-7/-2"};
        tbl[3] = '{1'b0, 32'h00001234,   32'd0,          64'h0,                 2,  "u/0"};
        tbl[4] = '{1'b1, 32'h00001234,   32'd0,          64'h0,                 2,  "s/0"};
        tbl[5] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, "s7/-2"};
        tbl[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, "umax/1"};
        tbl[7] = '{1'b0, 32'd3,          32'd7,          64'h00000003_00000000, 33, "u3/7"};
        tbl[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33, "u80000000/max"};

        rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
        #1;
        tick(); tick(); tick();
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].nm);

        // Annul at edge 10 of an unsigned 0xFFFFFFFF/3, then restart.
        signed_div = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; start = 1'b1;
        early = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (ready) early = 1'b1;
        end
        chk("annul no early ready", 64'(early), 64'd0);
        annul = 1'b1;
        tick();
        annul = 1'b0; start = 1'b0;
        chk("annul ready", 64'(ready), 64'd0);
        chk("annul result", result, 64'd0);
        tick();
        chk("annul idle ready", 64'(ready), 64'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd3, 64'h00000000_55555555, 33, "after annul");

        // Signed overflow with operands scrambled right after capture.
        signed_div = 1'b1; opdata1 = 32'h80000000; opdata2 = 32'hFFFFFFFF; start = 1'b1;
        tick();
        edges   = 1;
        opdata1 = $urandom;
        opdata2 = $urandom;
        signed_div = 1'b0;
        wait_ready(edges);
        chk("ovf latency", 64'(edges), 64'd33);
        chk("ovf result", result, 64'h00000000_80000000);
        start = 1'b0;
        tick();
        chk("ovf release", {63'd0, ready} | result, 64'd0);

        // Reset at edge 15 of an active division.
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (14) tick();
        rst = 1'b1; start = 1'b0;
        tick();
        chk("midrst ready", 64'(ready), 64'd0);
        chk("midrst result", result, 64'd0);
        rst = 1'b0;
        tick();
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "after rst");

        // Simultaneous start and annul in FREE must not launch an operation.
        signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
        tick(); tick(); tick();
        chk("start+annul ready", 64'(ready), 64'd0);
        start = 1'b0; annul = 1'b0;
        tick();
        run_op(1'b0, 32'd50, 32'd3, 64'h00000002_00000010, 33, "after start+annul");

        // annul while in END releases like start low.
        signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd2; start = 1'b1;
        edges = 0;
        wait_ready(edges);
        chk("end-annul result", result, 64'h00000001_00000004);
        annul = 1'b1;
        tick();
        chk("end-annul ready", 64'(ready), 64'd0);
        chk("end-annul cleared", result, 64'd0);
        annul = 1'b0; start = 1'b0;
        tick();

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rs   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 15));
                3:       begin ra = 32'h80000000; rb = $urandom; end
                default: rb = $urandom;
            endcase
            run_op(rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'd0) ? 2 : 33, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed/unsigned divider for the EX stage. It executes DIV and DIVU and feeds the quotient and remainder to the EX stage, which writes them to HI/LO.
- The EX stage asserts start and holds it until ready. While busy, the EX stage holds the pipeline in a stall.
- Result layout: result[63:32] = remainder (HI), result[31:0] = quotient (LO).

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset
signed_div  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
opdata1  input  WIDTH  dividend
opdata2  input  WIDTH  divisor
start  input  1  request; held high by EX until ready is seen
annul  input  1  abort the current operation (pipeline flush)
result  output  2*WIDTH  {remainder, quotient}
ready  output  1  result valid

Behaviour:
- Reset: rst is synchronous, active-high. On a reset edge: state = FREE, ready = 0, result = 0, iteration counter = 0, internal operand registers = 0. Reset mid-operation discards all work.
- States are FREE, BYZERO, ON and END. All outputs are registered.
- FREE:
  - On an edge with start=1, annul=0 and opdata2==0: go to BYZERO.
  - On an edge with start=1, annul=0 and opdata2!=0: go to ON, clear the counter, and latch the operands.
  - When signed_div=1, the latched operands are the absolute values of opdata1 and opdata2. The sign of each operand is also latched.
  - Operand changes after this capture edge are ignored.
  - Otherwise stay in FREE with ready=0 and result=0.
- BYZERO: on the next edge go to END with result = 0 and ready = 1.
- ON:
  - Each edge performs one restoring shift-subtract step on a (2*WIDTH+1)-bit working register, producing one quotient bit.
  - After WIDTH steps, the same edge applies sign correction, loads result, sets ready = 1, and goes to END.
  - Latency: counting the start-capture edge as edge 1, ready is first high after edge WIDTH+1 (33 for the default).
- ON with annul=1: on the next edge go to FREE with ready = 0 and result = 0. No partial result is ever presented.
- start going low during ON is ignored; only annul or rst aborts.
- END:
  - While start=1, hold result and ready=1.
  - On the first edge with start=0, go to FREE with ready = 0 and result = 0.
  - annul in END behaves like start=0.
- Back-to-back operations require start to be low for at least one edge between them.
- Sign correction (signed_div=1 only):
  - The quotient is negated (two's complement) if the dividend sign differs from the divisor sign.
  - The remainder takes the dividend's sign.
  - Unsigned mode applies no correction.
- Overflow case: 0x80000000 / 0xFFFFFFFF in signed mode gives quotient 0x80000000 and remainder 0x00000000, with no trap.
- Divide by zero gives result = 0 in both modes, with no exception.
- Simultaneous start and annul in FREE: annul wins and the block stays in FREE.

Test Plan:
- Unsigned: signed_div=0, opdata1=100, opdata2=7, start held. Required: ready rises after edge 33, result = {32'd2, 32'd14}; ready and result hold while start=1; both return to 0 one edge after start drops.
- Signed mixed signs: opdata1=0xFFFFFFF9 (-7), opdata2=2, signed_div=1. Required: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with opdata2=0xFFFFFFFE (-2): quotient 3, remainder 0xFFFFFFFF.
- Divide by zero: opdata1=0x1234, opdata2=0. Required: ready=1 after edge 2 (FREE→BYZERO→END), result = 0.
- Annul mid-operation:
  - Start 0xFFFFFFFF/3 unsigned and assert annul for one cycle at edge 10. Required: ready stays 0, state returns to FREE, result = 0.
  - Then drop start for one cycle and start again. Required: the new operation completes with quotient 0x55555555, remainder 0, after 33 edges.
- Signed overflow and operand stability: start 0x80000000 / 0xFFFFFFFF signed, then change opdata1 and opdata2 on the cycle after capture. Required: result = {0x00000000, 0x80000000}, unaffected by the operand changes.
- Reset mid-operation: assert rst at edge 15 of an active division. Required: ready=0 and result=0 after that edge. After rst deasserts, a fresh 100/7 gives {2, 14} with the full 33-edge latency.
